// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM->WB pipeline register with a one-entry skid buffer.
//
// Holds a main entry (drives the WB outputs) and a skid entry that absorbs
// one upstream transfer while WB is stalled, so in_ready can be registered.
// Also exposes a forwarding view of the main entry and a saturating count
// of WB stall cycles.
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   flush                       kill both held entries (wins over accept/pop)
//   in_valid / in_ready         upstream handshake (in_ready registered)
//   in_regwrite, in_memtoreg,
//   in_rd, in_addr, in_rdata    MEM-stage entry fields
//   out_valid / out_ready       WB handshake
//   out_regwrite .. out_rdata   held main entry fields (registered)
//   fwd_valid, fwd_rd, fwd_data combinational forwarding view of main entry
//   stall_cnt                   saturating count of out_valid & !out_ready
module mem_wb_stage #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned RD_W   = 5,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_regwrite,
    input  logic              in_memtoreg,
    input  logic [RD_W-1:0]   in_rd,
    input  logic [DATA_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_regwrite,
    output logic              out_memtoreg,
    output logic [RD_W-1:0]   out_rd,
    output logic [DATA_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_rdata,
    output logic              fwd_valid,
    output logic [RD_W-1:0]   fwd_rd,
    output logic [DATA_W-1:0] fwd_data,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state;
    state_t next_state;

    logic              skid_regwrite;
    logic              skid_memtoreg;
    logic [RD_W-1:0]   skid_rd;
    logic [DATA_W-1:0] skid_addr;
    logic [DATA_W-1:0] skid_rdata;

    logic accept;
    logic pop;
    logic in_regwrite_masked;
    logic load_main_in;
    logic load_main_skid;
    logic load_skid;

    assign accept = in_valid & in_ready & ~flush;
    assign pop    = out_valid & out_ready;

    // x0 is hardwired zero, so an entry targeting it never writes or forwards.
    assign in_regwrite_masked = in_regwrite & (in_rd != '0);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= EMPTY;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; flush overrides any transfer.
    always_comb begin
        next_state = state;
        if (flush) begin
            next_state = EMPTY;
        end else begin
            unique case (state)
                EMPTY: if (accept) next_state = ONE;
                ONE: begin
                    if (accept && !pop)      next_state = FULL;
                    else if (pop && !accept) next_state = EMPTY;
                end
                FULL:    if (pop) next_state = ONE;
                default: next_state = EMPTY;
            endcase
        end
    end

    // Datapath load controls decoded from state and handshakes.
    always_comb begin
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (!flush) begin
            unique case (state)
                EMPTY: load_main_in = accept;
                ONE: begin
                    load_main_in = accept & pop;
                    load_skid    = accept & ~pop;
                end
                FULL:    load_main_skid = pop;
                default: ;
            endcase
        end
    end

    // Registered handshake outputs follow the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            out_valid <= (next_state != EMPTY);
            in_ready  <= (next_state != FULL);
        end
    end

    // Main entry: reloaded from input or promoted from skid; otherwise held.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_regwrite <= 1'b0;
            out_memtoreg <= 1'b0;
            out_rd       <= '0;
            out_addr     <= '0;
            out_rdata    <= '0;
        end else if (load_main_in) begin
            out_regwrite <= in_regwrite_masked;
            out_memtoreg <= in_memtoreg;
            out_rd       <= in_rd;
            out_addr     <= in_addr;
            out_rdata    <= in_rdata;
        end else if (load_main_skid) begin
            out_regwrite <= skid_regwrite;
            out_memtoreg <= skid_memtoreg;
            out_rd       <= skid_rd;
            out_addr     <= skid_addr;
            out_rdata    <= skid_rdata;
        end
    end

    // Skid entry: captures the input only when main is stalled.
    always_ff @(posedge clk) begin
        if (reset) begin
            skid_regwrite <= 1'b0;
            skid_memtoreg <= 1'b0;
            skid_rd       <= '0;
            skid_addr     <= '0;
            skid_rdata    <= '0;
        end else if (load_skid) begin
            skid_regwrite <= in_regwrite_masked;
            skid_memtoreg <= in_memtoreg;
            skid_rd       <= in_rd;
            skid_addr     <= in_addr;
            skid_rdata    <= in_rdata;
        end
    end

    // Saturating stall counter; flush does not touch it.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    // Forwarding view of the main entry.
    assign fwd_valid = out_valid & out_regwrite;
    assign fwd_rd    = out_rd;
    assign fwd_data  = out_memtoreg ? out_rdata : out_addr;

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: directed + random scoreboard bench for mem_wb_stage.
module tb_mem_wb_stage;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned RD_W   = 5;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned CNT4_W = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              flush;
    logic              in_valid;
    logic              in_regwrite;
    logic              in_memtoreg;
    logic [RD_W-1:0]   in_rd;
    logic [DATA_W-1:0] in_addr;
    logic [DATA_W-1:0] in_rdata;
    logic              out_ready;

    logic              in_ready, out_valid, out_regwrite, out_memtoreg, fwd_valid;
    logic [RD_W-1:0]   out_rd, fwd_rd;
    logic [DATA_W-1:0] out_addr, out_rdata, fwd_data;
    logic [CNT_W-1:0]  stall_cnt;

    logic              in_ready_4, out_valid_4, out_regwrite_4, out_memtoreg_4, fwd_valid_4;
    logic [RD_W-1:0]   out_rd_4, fwd_rd_4;
    logic [DATA_W-1:0] out_addr_4, out_rdata_4, fwd_data_4;
    logic [CNT4_W-1:0] stall_cnt_4;

    always #5 clk = ~clk;

    mem_wb_stage #(.DATA_W(DATA_W), .RD_W(RD_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_regwrite(in_regwrite), .in_memtoreg(in_memtoreg),
        .in_rd(in_rd), .in_addr(in_addr), .in_rdata(in_rdata),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_regwrite(out_regwrite), .out_memtoreg(out_memtoreg),
        .out_rd(out_rd), .out_addr(out_addr), .out_rdata(out_rdata),
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
        .stall_cnt(stall_cnt)
    );

    mem_wb_stage #(.DATA_W(DATA_W), .RD_W(RD_W), .CNT_W(CNT4_W)) dut4 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_4),
        .in_regwrite(in_regwrite), .in_memtoreg(in_memtoreg),
        .in_rd(in_rd), .in_addr(in_addr), .in_rdata(in_rdata),
        .out_valid(out_valid_4), .out_ready(out_ready),
        .out_regwrite(out_regwrite_4), .out_memtoreg(out_memtoreg_4),
        .out_rd(out_rd_4), .out_addr(out_addr_4), .out_rdata(out_rdata_4),
        .fwd_valid(fwd_valid_4), .fwd_rd(fwd_rd_4), .fwd_data(fwd_data_4),
        .stall_cnt(stall_cnt_4)
    );

    typedef struct packed {
        logic              rw;
        logic              mtr;
        logic [RD_W-1:0]   rd;
        logic [DATA_W-1:0] addr;
        logic [DATA_W-1:0] rdata;
    } ent_t;

    ent_t        q[$];
    int          checks    = 0;
    int          failures  = 0;
    int          accepted  = 0;
    int unsigned exp_stall  = 0;
    int unsigned exp_stall4 = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare outputs against the model for the upcoming edge, then advance the model.
    task automatic check_cycle();
        bit   m_valid, m_ready, acc, pop_e;
        ent_t e;
        if (reset) begin
            q.delete();
            exp_stall  = 0;
            exp_stall4 = 0;
            return;
        end
        m_valid = (q.size() > 0);
        m_ready = (q.size() < 2);
        chk("out_valid", 64'(out_valid), 64'(m_valid));
        chk("in_ready", 64'(in_ready), 64'(m_ready));
        chk("out_valid_4", 64'(out_valid_4), 64'(m_valid));
        chk("stall_cnt", 64'(stall_cnt), 64'(exp_stall));
        chk("stall_cnt_4", 64'(stall_cnt_4), 64'(exp_stall4));
        if (m_valid) begin
            e = q[0];
            chk("out_regwrite", 64'(out_regwrite), 64'(e.rw));
            chk("out_memtoreg", 64'(out_memtoreg), 64'(e.mtr));
            chk("out_rd", 64'(out_rd), 64'(e.rd));
            chk("out_addr", 64'(out_addr), 64'(e.addr));
            chk("out_rdata", 64'(out_rdata), 64'(e.rdata));
            chk("fwd_valid", 64'(fwd_valid), 64'(e.rw));
            chk("fwd_rd", 64'(fwd_rd), 64'(e.rd));
            chk("fwd_data", 64'(fwd_data), 64'(e.mtr ? e.rdata : e.addr));
        end else begin
            chk("fwd_valid_idle", 64'(fwd_valid), 64'(0));
        end
        if (m_valid && !out_ready) begin
            if (exp_stall < 65535) exp_stall++;
            if (exp_stall4 < 15) exp_stall4++;
        end
        acc   = in_valid && m_ready && !flush;
        pop_e = m_valid && out_ready;
        if (flush) begin
            q.delete();
        end else begin
            if (pop_e) void'(q.pop_front());
            if (acc) begin
                e.rw    = in_regwrite && (in_rd != '0);
                e.mtr   = in_memtoreg;
                e.rd    = in_rd;
                e.addr  = in_addr;
                e.rdata = in_rdata;
                q.push_back(e);
                accepted++;
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic rw, input logic mtr,
                         input logic [RD_W-1:0] rd, input logic [DATA_W-1:0] addr,
                         input logic [DATA_W-1:0] rdata);
        in_valid    = v;
        in_regwrite = rw;
        in_memtoreg = mtr;
        in_rd       = rd;
        in_addr     = addr;
        in_rdata    = rdata;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'(0));
        chk({tag, "_in_ready"}, 64'(in_ready), 64'(1));
        chk({tag, "_stall"}, 64'(stall_cnt), 64'(0));
        chk({tag, "_stall4"}, 64'(stall_cnt_4), 64'(0));
        chk({tag, "_out_rd"}, 64'(out_rd), 64'(0));
        chk({tag, "_out_addr"}, 64'(out_addr), 64'(0));
        chk({tag, "_out_rdata"}, 64'(out_rdata), 64'(0));
        chk({tag, "_out_ctl"}, 64'({out_regwrite, out_memtoreg}), 64'(0));
        chk({tag, "_fwd_valid"}, 64'(fwd_valid), 64'(0));
    endtask

    initial begin
        int start_acc;
        reset     = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
        step();
        step();
        check_reset_state("reset");
        reset = 1'b0;

        // Single ALU entry, one-cycle latency.
        out_ready = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 5'd7, 32'h100, 32'h0);
        step();
        chk("lat_out_valid", 64'(out_valid), 64'(1));
        chk("lat_out_rd", 64'(out_rd), 64'(7));
        chk("lat_fwd_data", 64'(fwd_data), 64'(32'h100));
        chk("lat_fwd_valid", 64'(fwd_valid), 64'(1));
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
        step();
        step();

        // Two entries into a stalled stage; third offer must be ignored.
        out_ready = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 5'd1, 32'hA, 32'h1);
        step();
        drive(1'b1, 1'b1, 1'b0, 5'd2, 32'hB, 32'h2);
        step();
        chk("skid_in_ready", 64'(in_ready), 64'(0));
        chk("skid_hold_rd", 64'(out_rd), 64'(1));
        drive(1'b1, 1'b1, 1'b0, 5'd9, 32'hC, 32'h3);
        step();
        step();
        chk("skid_hold_rd2", 64'(out_rd), 64'(1));
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
        out_ready = 1'b1;
        step();
        chk("skid_second_rd", 64'(out_rd), 64'(2));
        step();
        chk("skid_drained", 64'(out_valid), 64'(0));

        // Load forwarding and x0 suppression.
        out_ready = 1'b0;
        drive(1'b1, 1'b1, 1'b1, 5'd3, 32'h40, 32'hDEADBEEF);
        step();
        chk("load_fwd_data", 64'(fwd_data), 64'(32'hDEADBEEF));
        drive(1'b1, 1'b1, 1'b0, 5'd0, 32'h55, 32'h0);
        step();
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
        out_ready = 1'b1;
        step();
        chk("x0_out_rd", 64'(out_rd), 64'(0));
        chk("x0_out_regwrite", 64'(out_regwrite), 64'(0));
        chk("x0_fwd_valid", 64'(fwd_valid), 64'(0));
        step();

        // Flush while FULL with a competing input.
        out_ready = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 5'd4, 32'h44, 32'h0);
        step();
        drive(1'b1, 1'b1, 1'b0, 5'd5, 32'h55, 32'h0);
        step();
        flush = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 5'd6, 32'h66, 32'h0);
        step();
        flush = 1'b0;
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
        chk("flush_out_valid", 64'(out_valid), 64'(0));
        chk("flush_in_ready", 64'(in_ready), 64'(1));
        out_ready = 1'b1;
        step();
        step();

        // Reset while FULL overrides flush/accept/pop.
        out_ready = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 5'd10, 32'hAA, 32'h0);
        step();
        drive(1'b1, 1'b1, 1'b0, 5'd11, 32'hBB, 32'h0);
        step();
        reset     = 1'b1;
        flush     = 1'b1;
        out_ready = 1'b1;
        step();
        reset = 1'b0;
        flush = 1'b0;
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
        check_reset_state("midrst");

        // Stall counter saturation on the narrow instance.
        out_ready = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 5'd12, 32'hCC, 32'h0);
        step();
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
        for (int i = 0; i < 20; i++) step();
        chk("sat_stall4", 64'(stall_cnt_4), 64'(15));
        chk("sat_stall16", 64'(stall_cnt), 64'(20));
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("sat_reset_stall4", 64'(stall_cnt_4), 64'(0));

        // Random back-to-back traffic with random backpressure.
        start_acc = accepted;
        for (int cyc = 0; cyc < 3000 && (accepted - start_acc) < 100; cyc++) begin
            drive(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                  $urandom(), $urandom());
            out_ready = 1'($urandom_range(0, 1));
            step();
        end
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();
        chk("rand_accepted", 64'(accepted - start_acc), 64'(100));
        chk("rand_drained", 64'(q.size()), 64'(0));
        chk("rand_out_valid", 64'(out_valid), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 Parameter DATA_W, default 32, width of address/result and load-data fields.
REQ-002 Parameter RD_W, default 5, destination-register index width.
REQ-003 Parameter CNT_W, default 16, width of the stall counter.
REQ-004 clk  input  1  single clock; all state updates on posedge clk.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 flush  input  1  kill all held entries; in_valid on the same cycle is dropped.
REQ-007 in_valid  input  1  upstream (MEM) entry valid.
REQ-008 in_ready  output  1  stage can accept; registered, equals !skid_valid.
REQ-009 in_regwrite, in_memtoreg  input  1 each  MEM-stage control bits.
REQ-010 in_rd  input  RD_W  destination register.
REQ-011 in_addr, in_rdata  input  DATA_W each  ALU result/address; load data.
REQ-012 out_valid  output  1  WB entry valid.
REQ-013 out_ready  input  1  WB consumer accepts.
REQ-014 out_regwrite, out_memtoreg, out_rd, out_addr, out_rdata  output  widths as inputs  held entry fields.
REQ-015 fwd_valid  output  1  out_valid & out_regwrite (combinational).
REQ-016 fwd_rd, fwd_data  output  RD_W / DATA_W  out_rd; out_memtoreg ? out_rdata : out_addr (combinational).
REQ-017 stall_cnt  output  CNT_W  count of cycles with out_valid & !out_ready.

Function
REQ-018 Storage: main entry (drives outputs) plus one skid entry; each entry carries a valid bit.
REQ-019 States: EMPTY (none valid), ONE (main only), FULL (main+skid); skid never valid without main.
REQ-020 Accept = in_valid & in_ready & !flush; pop = out_valid & out_ready.
REQ-021 EMPTY: accept -> ONE, input captured into main; else stay.
REQ-022 ONE: accept & pop -> ONE, main reloaded from input; accept & !pop -> FULL, input into skid; pop & !accept -> EMPTY.
REQ-023 FULL: in_ready=0; pop -> ONE, skid moved to main, skid invalidated; else hold.
REQ-024 Latency 1 cycle input-to-output from EMPTY; sustained throughput 1 entry/cycle with out_ready=1.
REQ-025 While out_valid & !out_ready, all out_* fields stable cycle to cycle.
REQ-026 On capture, regwrite stored as in_regwrite & (in_rd != 0); x0 never forwarded or written.
REQ-027 flush: next cycle both entries invalid, state EMPTY, in_ready=1; data fields may retain old values; flush takes priority over accept and pop.
REQ-028 stall_cnt increments by 1 per stalled cycle, saturates at all-ones, never wraps; unaffected by flush.
REQ-029 Entries accepted while in_ready=0 are impossible by construction; in_valid with in_ready=0 is ignored, no state change.

Reset
REQ-030 reset=1 at posedge: both valid bits 0, state EMPTY, in_ready=1, stall_cnt=0, all out_* data/control fields 0.
REQ-031 reset overrides flush, accept and pop on the same cycle; mid-operation reset discards FULL contents.
REQ-032 First accept possible on the first posedge after reset deasserts.

Verification
REQ-033 Reset, then in_valid=1, rd=7, addr=0x100, memtoreg=0, out_ready=1 -> next cycle out_valid=1, out_rd=7, fwd_data=0x100, fwd_valid=1.
REQ-034 out_ready=0, push entries A(rd=1) and B(rd=2) on consecutive cycles -> in_ready=0 after B, out holds A; raise out_ready -> A then B appear in order, none lost or duplicated.
REQ-035 Load entry rd=3, memtoreg=1, rdata=0xDEADBEEF, addr=0x40 -> fwd_data=0xDEADBEEF; entry with rd=0, regwrite=1 -> out_regwrite=0, fwd_valid=0.
REQ-036 FULL state, assert flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, dropped input never appears.
REQ-037 CNT_W=4, hold out_valid=1, out_ready=0 for 20 cycles -> stall_cnt reaches 15 and stays 15; reset -> 0.
REQ-038 Back-to-back 100 random entries with random out_ready and flush=0 -> output sequence matches input sequence exactly.
